// File: rtl/difftest_arch_int_reg_shadow_if.sv
// Commit write bus from the ROB commit ports into the difftest integer register shadow.
// master = ROB commit side, slave = shadow register file.
interface difftest_arch_int_reg_shadow_if #(
    parameter int NUM_PORTS = 6,
    parameter int XLEN      = 64
);
    logic [NUM_PORTS-1:0]      io_wen;
    logic [NUM_PORTS*5-1:0]    io_waddr;
    logic [NUM_PORTS*XLEN-1:0] io_wdata;
    logic [7:0]                io_coreid_in;

    modport master (
        output io_wen,
        output io_waddr,
        output io_wdata,
        output io_coreid_in
    );

    modport slave (
        input io_wen,
        input io_waddr,
        input io_wdata,
        input io_coreid_in
    );
endinterface

// File: rtl/difftest_arch_int_reg_shadow.sv
// Shadow architectural integer register file feeding the difftest ArchIntRegState sink.
// Optional macro DIFFTEST_INTREG_EVERY_CYCLE_EN: strobe enable every cycle instead of only after commits.
module difftest_arch_int_reg_shadow #(
    parameter int NUM_PORTS = 6,
    parameter int XLEN      = 64
) (
    input  logic                              clock,
    input  logic                              reset,
    difftest_arch_int_reg_shadow_if.slave     i_commit,
    output logic                              enable,
    output logic [XLEN-1:0]                   io_value_0,
    output logic [XLEN-1:0]                   io_value_1,
    output logic [XLEN-1:0]                   io_value_2,
    output logic [XLEN-1:0]                   io_value_3,
    output logic [XLEN-1:0]                   io_value_4,
    output logic [XLEN-1:0]                   io_value_5,
    output logic [XLEN-1:0]                   io_value_6,
    output logic [XLEN-1:0]                   io_value_7,
    output logic [XLEN-1:0]                   io_value_8,
    output logic [XLEN-1:0]                   io_value_9,
    output logic [XLEN-1:0]                   io_value_10,
    output logic [XLEN-1:0]                   io_value_11,
    output logic [XLEN-1:0]                   io_value_12,
    output logic [XLEN-1:0]                   io_value_13,
    output logic [XLEN-1:0]                   io_value_14,
    output logic [XLEN-1:0]                   io_value_15,
    output logic [XLEN-1:0]                   io_value_16,
    output logic [XLEN-1:0]                   io_value_17,
    output logic [XLEN-1:0]                   io_value_18,
    output logic [XLEN-1:0]                   io_value_19,
    output logic [XLEN-1:0]                   io_value_20,
    output logic [XLEN-1:0]                   io_value_21,
    output logic [XLEN-1:0]                   io_value_22,
    output logic [XLEN-1:0]                   io_value_23,
    output logic [XLEN-1:0]                   io_value_24,
    output logic [XLEN-1:0]                   io_value_25,
    output logic [XLEN-1:0]                   io_value_26,
    output logic [XLEN-1:0]                   io_value_27,
    output logic [XLEN-1:0]                   io_value_28,
    output logic [XLEN-1:0]                   io_value_29,
    output logic [XLEN-1:0]                   io_value_30,
    output logic [XLEN-1:0]                   io_value_31,
    output logic [7:0]                        io_coreid,
    output logic [31:0]                       io_commit_cnt
);

    logic [XLEN-1:0] r_shadow [1:31];
    logic            r_enable;
    logic [31:0]     r_commitCnt;
    logic [7:0]      r_coreid;
    logic [31:0]     w_applyCnt;
    logic            w_enableNext;

    // Number of ports retiring a real (non-x0) register write this cycle.
    always_comb begin
        w_applyCnt = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (i_commit.io_wen[k] && (i_commit.io_waddr[5*k +: 5] != 5'd0)) begin
                w_applyCnt = w_applyCnt + 32'd1;
            end
        end
    end

`ifdef DIFFTEST_INTREG_EVERY_CYCLE_EN
    assign w_enableNext = 1'b1;
`else
    assign w_enableNext = |i_commit.io_wen;
`endif

    // Ports are scanned in ascending order so the last non-blocking write, the youngest port, wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 1; r < 32; r++) begin
                r_shadow[r] <= '0;
            end
            r_enable    <= 1'b0;
            r_commitCnt <= '0;
            r_coreid    <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (i_commit.io_wen[k] && (i_commit.io_waddr[5*k +: 5] == 5'(r))) begin
                        r_shadow[r] <= i_commit.io_wdata[XLEN*k +: XLEN];
                    end
                end
            end
            r_enable    <= w_enableNext;
            r_commitCnt <= r_commitCnt + w_applyCnt;
            r_coreid    <= i_commit.io_coreid_in;
        end
    end

    assign enable        = r_enable;
    assign io_commit_cnt = r_commitCnt;
    assign io_coreid     = r_coreid;

    assign io_value_0  = '0;
    assign io_value_1  = r_shadow[1];
    assign io_value_2  = r_shadow[2];
    assign io_value_3  = r_shadow[3];
    assign io_value_4  = r_shadow[4];
    assign io_value_5  = r_shadow[5];
    assign io_value_6  = r_shadow[6];
    assign io_value_7  = r_shadow[7];
    assign io_value_8  = r_shadow[8];
    assign io_value_9  = r_shadow[9];
    assign io_value_10 = r_shadow[10];
    assign io_value_11 = r_shadow[11];
    assign io_value_12 = r_shadow[12];
    assign io_value_13 = r_shadow[13];
    assign io_value_14 = r_shadow[14];
    assign io_value_15 = r_shadow[15];
    assign io_value_16 = r_shadow[16];
    assign io_value_17 = r_shadow[17];
    assign io_value_18 = r_shadow[18];
    assign io_value_19 = r_shadow[19];
    assign io_value_20 = r_shadow[20];
    assign io_value_21 = r_shadow[21];
    assign io_value_22 = r_shadow[22];
    assign io_value_23 = r_shadow[23];
    assign io_value_24 = r_shadow[24];
    assign io_value_25 = r_shadow[25];
    assign io_value_26 = r_shadow[26];
    assign io_value_27 = r_shadow[27];
    assign io_value_28 = r_shadow[28];
    assign io_value_29 = r_shadow[29];
    assign io_value_30 = r_shadow[30];
    assign io_value_31 = r_shadow[31];

endmodule

// File: tb/tb_difftest_arch_int_reg_shadow.sv
// Directed bench for difftest_arch_int_reg_shadow: vector table plus reset, wrap and x0 corner cases.
// Expectations follow DIFFTEST_INTREG_EVERY_CYCLE_EN when it is defined for the build.
module tb_difftest_arch_int_reg_shadow;

    localparam int NP = 6;
    localparam int XL = 64;

`ifdef DIFFTEST_INTREG_EVERY_CYCLE_EN
    localparam bit EVERY_CYCLE = 1'b1;
`else
    localparam bit EVERY_CYCLE = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          enable;
    logic [7:0]    io_coreid;
    logic [31:0]   io_commit_cnt;
    logic [XL-1:0] vals [32];

    int assertCount;
    int failCount;

    difftest_arch_int_reg_shadow_if #(.NUM_PORTS(NP), .XLEN(XL)) busIf ();

    difftest_arch_int_reg_shadow #(.NUM_PORTS(NP), .XLEN(XL)) dut (
        .clock(clock), .reset(reset), .i_commit(busIf.slave), .enable(enable),
        .io_value_0(vals[0]),   .io_value_1(vals[1]),   .io_value_2(vals[2]),   .io_value_3(vals[3]),
        .io_value_4(vals[4]),   .io_value_5(vals[5]),   .io_value_6(vals[6]),   .io_value_7(vals[7]),
        .io_value_8(vals[8]),   .io_value_9(vals[9]),   .io_value_10(vals[10]), .io_value_11(vals[11]),
        .io_value_12(vals[12]), .io_value_13(vals[13]), .io_value_14(vals[14]), .io_value_15(vals[15]),
        .io_value_16(vals[16]), .io_value_17(vals[17]), .io_value_18(vals[18]), .io_value_19(vals[19]),
        .io_value_20(vals[20]), .io_value_21(vals[21]), .io_value_22(vals[22]), .io_value_23(vals[23]),
        .io_value_24(vals[24]), .io_value_25(vals[25]), .io_value_26(vals[26]), .io_value_27(vals[27]),
        .io_value_28(vals[28]), .io_value_29(vals[29]), .io_value_30(vals[30]), .io_value_31(vals[31]),
        .io_coreid(io_coreid), .io_commit_cnt(io_commit_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [NP-1:0]    wen;
        logic [NP*5-1:0]  waddr;
        logic [NP*XL-1:0] wdata;
        int               checkIdx;
        logic [XL-1:0]    expVal;
        logic [31:0]      expCnt;
        logic             expEn;
    } vec_t;

    localparam int NUM_VECS = 10;
    vec_t vecs [NUM_VECS];

    logic [NP-1:0]    stimWen;
    logic [NP*5-1:0]  stimAddr;
    logic [NP*XL-1:0] stimData;

    task automatic applyStimulus(input logic [NP-1:0] wen, input logic [NP*5-1:0] waddr,
                                 input logic [NP*XL-1:0] wdata);
        busIf.io_wen   = wen;
        busIf.io_waddr = waddr;
        busIf.io_wdata = wdata;
    endtask

    task automatic checkOutput(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clearVec(input int idx);
        vecs[idx].wen      = '0;
        vecs[idx].waddr    = '0;
        vecs[idx].wdata    = '0;
        vecs[idx].checkIdx = 0;
        vecs[idx].expVal   = '0;
        vecs[idx].expCnt   = '0;
        vecs[idx].expEn    = 1'b0;
    endtask

    task automatic addWrite(input int idx, input int port, input logic [4:0] addr, input logic [XL-1:0] data);
        vecs[idx].wen[port]            = 1'b1;
        vecs[idx].waddr[5*port +: 5]   = addr;
        vecs[idx].wdata[XL*port +: XL] = data;
    endtask

    task automatic setExpect(input int idx, input int reg_i, input logic [XL-1:0] v,
                             input logic [31:0] cnt, input logic en);
        vecs[idx].checkIdx = reg_i;
        vecs[idx].expVal   = v;
        vecs[idx].expCnt   = cnt;
        vecs[idx].expEn    = en;
    endtask

    task automatic addStim(input int port, input logic [4:0] addr, input logic [XL-1:0] data);
        stimWen[port]            = 1'b1;
        stimAddr[5*port +: 5]    = addr;
        stimData[XL*port +: XL]  = data;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;

        for (int i = 0; i < NUM_VECS; i++) clearVec(i);
        // Expected count is cumulative from reset; expEn is the default-build strobe.
        addWrite(0, 0, 5'd5, 64'hDEAD_BEEF_0000_0001);
        setExpect(0, 5, 64'hDEAD_BEEF_0000_0001, 32'd1, 1'b1);
        setExpect(1, 5, 64'hDEAD_BEEF_0000_0001, 32'd1, 1'b0);
        addWrite(2, 1, 5'd10, 64'h11);
        addWrite(2, 4, 5'd10, 64'h44);
        setExpect(2, 10, 64'h44, 32'd3, 1'b1);
        addWrite(3, 2, 5'd0, 64'hFFFF);
        setExpect(3, 0, 64'h0, 32'd3, 1'b1);
        for (int p = 0; p < NP; p++) addWrite(4, p, 5'(p + 1), 64'hA000_0000_0000_0000 | 64'(p + 1));
        setExpect(4, 6, 64'hA000_0000_0000_0006, 32'd9, 1'b1);
        setExpect(5, 1, 64'hA000_0000_0000_0001, 32'd9, 1'b0);
        addWrite(6, 0, 5'd31, 64'h1);
        addWrite(6, 5, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        setExpect(6, 31, 64'hFFFF_FFFF_FFFF_FFFF, 32'd11, 1'b1);
        addWrite(7, 3, 5'd5, 64'h1234);
        setExpect(7, 5, 64'h1234, 32'd12, 1'b1);
        addWrite(8, 0, 5'd0, 64'h5);
        addWrite(8, 1, 5'd7, 64'h77);
        setExpect(8, 7, 64'h77, 32'd13, 1'b1);
        setExpect(9, 10, 64'h44, 32'd13, 1'b0);

        reset              = 1'b1;
        busIf.io_coreid_in = 8'h3C;
        applyStimulus('0, '0, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_coreid", 64'(io_coreid), 64'h0);
        checkOutput("reset_cnt", 64'(io_commit_cnt), 64'h0);
        checkOutput("reset_enable", 64'(enable), 64'h0);
        reset = 1'b0;

        // Idle after reset: first cycle strobe is 0 in every build.
        for (int c = 0; c < 3; c++) begin
            if (c > 0) checkOutput($sformatf("idle%0d_enable", c), 64'(enable), 64'(EVERY_CYCLE));
            else       checkOutput("idle0_enable", 64'(enable), 64'h0);
            checkOutput($sformatf("idle%0d_cnt", c), 64'(io_commit_cnt), 64'h0);
            checkOutput($sformatf("idle%0d_x%0d", c, 9 * c + 3), vals[9 * c + 3], 64'h0);
            @(negedge clock);
        end
        checkOutput("coreid_tracks", 64'(io_coreid), 64'h3C);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
            @(negedge clock);
            checkOutput($sformatf("vec%0d_x%0d", i, vecs[i].checkIdx), vals[vecs[i].checkIdx], vecs[i].expVal);
            checkOutput($sformatf("vec%0d_cnt", i), 64'(io_commit_cnt), 64'(vecs[i].expCnt));
            checkOutput($sformatf("vec%0d_enable", i), 64'(enable), 64'(vecs[i].expEn | EVERY_CYCLE));
        end
        checkOutput("x0_const", vals[0], 64'h0);

        // Count wrap: preload near the top, then retire three real writes in one cycle.
        stimWen = '0; stimAddr = '0; stimData = '0;
        addStim(0, 5'd1, 64'h101);
        addStim(2, 5'd2, 64'h202);
        addStim(5, 5'd3, 64'h303);
        force dut.r_commitCnt = 32'hFFFF_FFFE;
        applyStimulus(stimWen, stimAddr, stimData);
        #3;
        release dut.r_commitCnt;
        @(negedge clock);
        checkOutput("wrap_cnt", 64'(io_commit_cnt), 64'h0000_0001);
        checkOutput("wrap_x3", vals[3], 64'h303);

        // Reset wins over a full cycle of commits.
        stimWen = '0; stimAddr = '0; stimData = '0;
        for (int p = 0; p < NP; p++) addStim(p, 5'(p + 1), 64'hBEEF_0000 | 64'(p));
        applyStimulus(stimWen, stimAddr, stimData);
        reset = 1'b1;
        @(negedge clock);
        for (int r = 0; r < 32; r++) checkOutput($sformatf("rstwr_x%0d", r), vals[r], 64'h0);
        checkOutput("rstwr_cnt", 64'(io_commit_cnt), 64'h0);
        checkOutput("rstwr_enable", 64'(enable), 64'h0);
        checkOutput("rstwr_coreid", 64'(io_coreid), 64'h0);

        // Commit in the first cycle after deassertion is applied normally.
        reset = 1'b0;
        stimWen = '0; stimAddr = '0; stimData = '0;
        addStim(0, 5'd9, 64'h9999_0000_1111_2222);
        applyStimulus(stimWen, stimAddr, stimData);
        #1;
        checkOutput("postrst_enable_low", 64'(enable), 64'h0);
        @(negedge clock);
        applyStimulus('0, '0, '0);
        checkOutput("postrst_x9", vals[9], 64'h9999_0000_1111_2222);
        checkOutput("postrst_cnt", 64'(io_commit_cnt), 64'h1);
        checkOutput("postrst_enable", 64'(enable), 64'h1);
        @(negedge clock);
        checkOutput("postrst_idle_enable", 64'(enable), 64'(EVERY_CYCLE));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/difftest_arch_int_reg_shadow.md
# difftest_arch_int_reg_shadow

Shadow architectural integer register file on the producer side of the difftest `ArchIntRegState` channel. It applies committed integer writebacks from the ROB commit ports to a 32-entry shadow copy and drives the full snapshot, the per-cycle `enable` strobe and `io_coreid` into the DPI sink. It sits beside the ROB commit logic and is instantiated only in difftest builds.

## Interface
- `NUM_PORTS`, 6, number of commit write ports per cycle (1..8)
- `XLEN`, 64, register width in bits

- `clock`  in  1  single clock domain
- `reset`  in  1  synchronous, active-high reset
- `io_wen`  in  NUM_PORTS  per-port commit write valid; bit k is port k
- `io_waddr`  in  NUM_PORTS*5  flattened destination indices; port k at [5k+4:5k]
- `io_wdata`  in  NUM_PORTS*XLEN  flattened write data; port k at [XLEN*k+XLEN-1:XLEN*k]
- `io_coreid_in`  in  8  hart ID, static after reset
- `enable`  out  1  snapshot strobe to the sink
- `io_value_0` .. `io_value_31`  out  XLEN each  registered shadow register values
- `io_coreid`  out  8  registered copy of `io_coreid_in`
- `io_commit_cnt`  out  32  running count of applied (non-x0) register writes

## Operation
- Shadow state: 31 XLEN-bit registers for x1..x31. `io_value_0` is the constant 0 and has no storage.
- Per cycle, for each register r in 1..31: new value = `io_wdata` of the highest-index port k with `io_wen[k]` set and `io_waddr[k]==r`. If there is no such port, the register holds its value.
- Port priority: a higher port index is later in program order, so it wins on a same-address collision. Lower-port data to the same register is discarded.
- Writes to x0 (`io_waddr==0`) are dropped. They do not count toward `io_commit_cnt`. They still count as commit activity for `enable`.
- `io_commit_cnt` increments by the number of ports with `io_wen` set and a nonzero address, 0..NUM_PORTS per cycle. Same-address collisions count once per port. The adder is 32-bit modulo and wraps from 0xFFFF_FFFF to 0 silently.
- `io_coreid` registers `io_coreid_in` every cycle.
- `enable` is a registered strobe, set per the Configuration section.

## Timing
- Reset (synchronous, `reset` high at a rising edge) sets:
  - x1..x31 to 0
  - `enable` to 0
  - `io_commit_cnt` to 0
  - `io_coreid` to 0
- All outputs are registered. `io_value_0` is the only combinational output and is constant 0.
- Write latency is 1 cycle. Writes presented at edge t appear on `io_value_*` after edge t, during cycle t+1.
- `enable` in cycle t+1 refers to the snapshot visible in cycle t+1, so the sink samples the post-commit state.
- Back-to-back commits on consecutive cycles give `enable` high on consecutive cycles. There is no backpressure; the sink always accepts.
- `reset` asserted while commits are present: reset wins. Those writes are lost, the count is not updated, and `enable` is 0 on the next cycle.
- First cycle after reset deassertion: `enable` is 0. Commits in that cycle are applied normally.
- There is no state machine beyond the shadow registers, the count accumulator and the `enable` flop.

## Configuration
- `DIFFTEST_INTREG_EVERY_CYCLE_EN`
  - Defined: `enable` is 1 on every cycle after the first post-reset edge, whether or not a commit occurred. The sink checks state every cycle. This is slower but catches spurious architectural corruption.
  - Undefined (default): `enable` is 1 in cycle t+1 only when any `io_wen` bit was set in cycle t, including x0-only commits.
- The macro affects only `enable` generation. Shadow update and count logic are identical in both builds.

## Test plan
- Reset, then idle for 3 cycles. Required: all `io_value_*` = 0, `io_commit_cnt` = 0. `enable` stays 0 with the macro undefined; `enable` is 1 from the 2nd post-reset cycle with it defined.
- Port 0 writes x5 = 0xDEAD_BEEF_0000_0001. Required: next cycle `io_value_5` = 0xDEAD_BEEF_0000_0001, `enable` = 1 for one cycle, `io_commit_cnt` = 1.
- Ports 1 and 4 both write x10, with 0x11 and 0x44, in the same cycle. Required: `io_value_10` = 0x44, `io_commit_cnt` += 2.
- Port 2 writes x0 = 0xFFFF. Required: `io_value_0` = 0, count unchanged, `enable` = 1 next cycle.
- Preload the count to 0xFFFF_FFFE via 0xFFFF_FFFE single writes (or by forcing it), then do one cycle with 3 valid nonzero-address writes. Required: `io_commit_cnt` = 0x0000_0001.
- Assert `reset` in the same cycle as 6 valid writes to x1..x6. Required: next cycle all values = 0, count = 0, `enable` = 0.
